// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network MAC layers.
package nn_pkg;

    localparam int WORD_W    = 32;
    localparam int ACC_W     = 64;
    localparam int FRAC_BITS = 16;

    localparam int L0_IN  = 784;
    localparam int L0_OUT = 128;
    localparam int L1_IN  = 128;
    localparam int L1_OUT = 10;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {IDLE, REQ, ACCUM, DONE} mac_state_t;

    // Clamp a wide accumulator into a signed word, optionally zeroing negatives.
    function automatic logic [WORD_W-1:0] saturate(input logic signed [ACC_W-1:0] v,
                                                   input logic                    relu);
        if (relu && v[ACC_W-1])
            return '0;
        if (v > SAT_MAX)
            return SAT_MAX[WORD_W-1:0];
        if (v < SAT_MIN)
            return SAT_MIN[WORD_W-1:0];
        return v[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron lane: signed Q-format multiply, shift, 64-bit accumulate and
// saturating (optionally ReLU-clamped) result register.
module mac_lane
    import nn_pkg::*;
#(
    parameter int FRAC = FRAC_BITS,
    parameter bit RELU = 1'b0
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              load,
    input  logic [WORD_W-1:0] weight,
    input  logic [WORD_W-1:0] act,
    output logic [WORD_W-1:0] result
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] acc_next;

    always_comb begin
        product  = (ACC_W'($signed(weight)) * ACC_W'($signed(act))) >>> FRAC;
        acc_next = acc + product;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear)
                acc <= '0;
            else if (en)
                acc <= acc_next;
            // NOTE: load coincides with the last beat, so the sum must include this cycle's product.
            if (load)
                result <= saturate(acc_next, RELU);
        end
    end

endmodule

// File: rtl/layer_mac.sv
// Layer multiply-accumulate: requests a weight stream, walks the activation
// buffer, and publishes LANES saturated neuron sums with a done pulse.
module layer_mac
    import nn_pkg::*;
#(
    parameter int LANES = L0_OUT,
    parameter int DEPTH = L0_IN,
    parameter int FRAC  = FRAC_BITS,
    parameter bit RELU  = 1'b0
) (
    input  logic                     clka,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     w_start,
    input  logic [LANES*WORD_W-1:0]  w_values,
    output logic [$clog2(DEPTH)-1:0] act_addr,
    input  logic [WORD_W-1:0]        act_data,
    output logic                     busy,
    output logic                     done,
    output logic [LANES*WORD_W-1:0]  result
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    mac_state_t    state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] addr_next;
    logic          lane_clear;
    logic          lane_en;
    logic          lane_load;

    // Address runs one beat ahead of the data to cover the buffer's read latency.
    assign addr_next  = (act_addr == LAST) ? LAST : act_addr + 1'b1;
    assign lane_clear = (state == REQ);
    assign lane_en    = (state == ACCUM);
    assign lane_load  = lane_en && (cnt == LAST);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            act_addr <= '0;
            w_start  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            w_start <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    act_addr <= '0;
                    if (start) begin
                        state   <= REQ;
                        w_start <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    state    <= ACCUM;
                    cnt      <= '0;
                    act_addr <= addr_next;
                end
                ACCUM: begin
                    act_addr <= addr_next;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    act_addr <= '0;
                    if (start) begin
                        state   <= REQ;
                        w_start <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .FRAC (FRAC),
            .RELU (RELU)
        ) u_lane (
            .clka   (clka),
            .rst_n  (rst_n),
            .clear  (lane_clear),
            .en     (lane_en),
            .load   (lane_load),
            .weight (w_values[i*WORD_W +: WORD_W]),
            .act    (act_data),
            .result (result[i*WORD_W +: WORD_W])
        );
    end

endmodule

// File: tb/tb_layer_mac.sv
// Bench for layer_mac: three configurations driven by a modelled weight source
// and activation buffer, checked against a plain-arithmetic reference.
module tb_layer_mac;

    localparam int L0 = 128, D0 = 784;
    localparam int L1 = 10,  D1 = 128;
    localparam int L2 = 10,  D2 = 784;

    logic clka = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start_v = '0;

    logic              w_start0, w_start1, w_start2;
    logic [L0*32-1:0]  w_values0;
    logic [L1*32-1:0]  w_values1;
    logic [L2*32-1:0]  w_values2;
    logic [9:0]        act_addr0;
    logic [6:0]        act_addr1;
    logic [9:0]        act_addr2;
    logic [31:0]       act_data0, act_data1, act_data2;
    logic              busy0, busy1, busy2;
    logic              done0, done1, done2;
    logic [L0*32-1:0]  res0;
    logic [L1*32-1:0]  res1;
    logic [L2*32-1:0]  res2;

    int checks = 0;
    int errors = 0;

    // Stimulus state shared by the weight-source and buffer models.
    bit          wrand = 1'b0;
    logic [31:0] wconst = '0;
    logic [31:0] wbase [128];
    logic [31:0] wstep [128];
    logic [31:0] act_mem [784];
    logic [31:0] exp_res [128];
    logic [31:0] exp_a [128];
    int k0, k1, k2;

    always #5 clka = ~clka;

    layer_mac u0 (
        .clka(clka), .rst_n(rst_n), .start(start_v[0]), .w_start(w_start0),
        .w_values(w_values0), .act_addr(act_addr0), .act_data(act_data0),
        .busy(busy0), .done(done0), .result(res0)
    );

    layer_mac #(.LANES(L1), .DEPTH(D1), .FRAC(16), .RELU(1'b0)) u1 (
        .clka(clka), .rst_n(rst_n), .start(start_v[1]), .w_start(w_start1),
        .w_values(w_values1), .act_addr(act_addr1), .act_data(act_data1),
        .busy(busy1), .done(done1), .result(res1)
    );

    layer_mac #(.LANES(L2), .DEPTH(D2), .FRAC(16), .RELU(1'b1)) u2 (
        .clka(clka), .rst_n(rst_n), .start(start_v[2]), .w_start(w_start2),
        .w_values(w_values2), .act_addr(act_addr2), .act_data(act_data2),
        .busy(busy2), .done(done2), .result(res2)
    );

    function automatic logic [31:0] wval(int lane, int k);
        if (!wrand)
            return wconst;
        return wbase[lane] + 32'(k) * wstep[lane];
    endfunction

    // Weight source: row k appears two cycles after its w_start pulse plus k.
    always @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            k0 <= 0; k1 <= 0; k2 <= 0;
            w_values0 <= '0; w_values1 <= '0; w_values2 <= '0;
        end else begin
            for (int l = 0; l < L0; l++) w_values0[l*32 +: 32] <= wval(l, w_start0 ? 0 : k0 + 1);
            for (int l = 0; l < L1; l++) w_values1[l*32 +: 32] <= wval(l, w_start1 ? 0 : k1 + 1);
            for (int l = 0; l < L2; l++) w_values2[l*32 +: 32] <= wval(l, w_start2 ? 0 : k2 + 1);
            k0 <= w_start0 ? 0 : k0 + 1;
            k1 <= w_start1 ? 0 : k1 + 1;
            k2 <= w_start2 ? 0 : k2 + 1;
        end
    end

    always @(posedge clka) begin
        act_data0 <= act_mem[act_addr0];
        act_data1 <= act_mem[act_addr1];
        act_data2 <= act_mem[act_addr2];
    end

    function automatic int depth_of(int sel);
        return (sel == 1) ? D1 : D0;
    endfunction
    function automatic int lanes_of(int sel);
        return (sel == 0) ? L0 : L1;
    endfunction
    function automatic bit relu_of(int sel);
        return sel == 2;
    endfunction
    function automatic logic get_wstart(int sel);
        case (sel) 0: return w_start0; 1: return w_start1; default: return w_start2; endcase
    endfunction
    function automatic logic get_busy(int sel);
        case (sel) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(int sel);
        case (sel) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction
    function automatic int get_addr(int sel);
        case (sel) 0: return int'(act_addr0); 1: return int'(act_addr1); default: return int'(act_addr2); endcase
    endfunction
    function automatic logic [31:0] get_res(int sel, int lane);
        case (sel) 0: return res0[lane*32 +: 32]; 1: return res1[lane*32 +: 32]; default: return res2[lane*32 +: 32]; endcase
    endfunction

    // Reference: sum of arithmetically shifted products, then clamp.
    function automatic logic [31:0] model_lane(int lane, int depth, bit relu);
        longint acc = 0;
        for (int k = 0; k < depth; k++)
            acc += (longint'($signed(wval(lane, k))) * longint'($signed(act_mem[k]))) >>> 16;
        if (relu && acc < 0) return 32'd0;
        if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    task automatic compute_expected(input int sel);
        for (int l = 0; l < lanes_of(sel); l++)
            exp_res[l] = model_lane(l, depth_of(sel), relu_of(sel));
    endtask

    function automatic int first_bad(int sel);
        for (int l = 0; l < lanes_of(sel); l++)
            if (get_res(sel, l) !== exp_res[l]) return l;
        return -1;
    endfunction

    function automatic logic [31:0] rnd(int bits);
        logic [31:0] v = $urandom;
        logic [31:0] mask;
        if (bits >= 32) return v;
        mask = (32'h1 << bits) - 32'h1;
        v = v & mask;
        if (v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_const(input logic [31:0] w, input logic [31:0] a);
        wrand = 1'b0;
        wconst = w;
        for (int k = 0; k < 784; k++) act_mem[k] = a;
    endtask

    task automatic set_random(input int wbits, input int abits);
        wrand = 1'b1;
        for (int l = 0; l < 128; l++) begin
            wbase[l] = rnd(wbits);
            wstep[l] = rnd(wbits > 10 ? wbits - 8 : 2);
        end
        for (int k = 0; k < 784; k++) act_mem[k] = rnd(abits);
    endtask

    // Starts (unless already started) one job and observes it cycle by cycle until done.
    task automatic watch(input int sel, input bit prestarted, input int xa, input int xb,
                         output int done_cyc, output int ws, output int ws_cyc,
                         output int addr_bad, output int busy_bad, output int held_bad);
        int depth = depth_of(sel);
        logic [31:0] snap [128];
        if (!prestarted) begin
            @(negedge clka); start_v[sel] = 1'b1;
            @(negedge clka); start_v[sel] = 1'b0;
        end
        done_cyc = 0; ws = 0; ws_cyc = 0; addr_bad = 0; busy_bad = 0; held_bad = 0;
        for (int l = 0; l < lanes_of(sel); l++) snap[l] = get_res(sel, l);
        for (int c = 1; c <= depth + 8; c++) begin
            if (get_wstart(sel) === 1'b1) begin
                ws++;
                if (ws_cyc == 0) ws_cyc = c;
            end
            if (get_addr(sel) != ((c <= depth) ? c - 1 : depth - 1)) addr_bad++;
            if (get_busy(sel) !== (c <= depth + 1)) busy_bad++;
            if (get_done(sel) === 1'b1) begin
                done_cyc = c;
                break;
            end
            for (int l = 0; l < lanes_of(sel); l++)
                if (get_res(sel, l) !== snap[l]) held_bad++;
            start_v[sel] = (c == xa || c == xb);
            @(negedge clka);
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_wstart(s) !== 1'b0 || get_busy(s) !== 1'b0 || get_done(s) !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got w_start=%b busy=%b done=%b expected 0 0 0",
                         s, get_wstart(s), get_busy(s), get_done(s));
            end
            checks++;
            if (get_addr(s) !== 0) begin
                errors++;
                $display("FAIL reset_addr[%0d]: got %0d expected 0", s, get_addr(s));
            end
            for (int l = 0; l < lanes_of(s); l++) exp_res[l] = '0;
            checks++;
            if (first_bad(s) != -1) begin
                errors++;
                $display("FAIL reset_result[%0d]: lane %0d got %h expected 0", s, first_bad(s), get_res(s, first_bad(s)));
            end
        end
    endtask

    task automatic test_layer0_const();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'd1520, 32'd65536);
        compute_expected(0);
        watch(0, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (dc != 786) begin errors++; $display("FAIL l0_latency: got cycle %0d expected 786", dc); end
        checks++;
        if (ws != 1 || wc != 1) begin errors++; $display("FAIL l0_wstart: got %0d pulses first at %0d expected 1 at 1", ws, wc); end
        checks++;
        if (ab + bb != 0) begin errors++; $display("FAIL l0_protocol: got %0d addr and %0d busy errors expected 0", ab, bb); end
        fb = first_bad(0);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL l0_results: lane %0d got %h expected %h", fb, get_res(0, fb), exp_res[fb]); end
        checks++;
        if (get_res(0, 127) !== 32'd1191680) begin errors++; $display("FAIL l0_lane127: got %0d expected 1191680", get_res(0, 127)); end
    endtask

    task automatic test_layer1_const();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'd320, 32'd65536);
        compute_expected(1);
        watch(1, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (dc != 130) begin errors++; $display("FAIL l1_latency: got cycle %0d expected 130", dc); end
        checks++;
        if (ab != 0) begin errors++; $display("FAIL l1_addr_seq: got %0d bad addresses expected 0", ab); end
        fb = first_bad(1);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL l1_results: lane %0d got %h expected %h", fb, get_res(1, fb), exp_res[fb]); end
        checks++;
        if (get_res(1, 0) !== 32'd40960) begin errors++; $display("FAIL l1_lane0: got %0d expected 40960", get_res(1, 0)); end
        @(negedge clka);
        checks++;
        if (get_done(1) !== 1'b0 || get_busy(1) !== 1'b0 || get_addr(1) != 0) begin
            errors++;
            $display("FAIL l1_after_done: got done=%b busy=%b addr=%0d expected 0 0 0", get_done(1), get_busy(1), get_addr(1));
        end
        repeat (3) @(negedge clka);
        checks++;
        if (get_res(1, 9) !== 32'd40960) begin errors++; $display("FAIL l1_idle_hold: got %0d expected 40960", get_res(1, 9)); end
    endtask

    task automatic test_saturate();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        compute_expected(1);
        watch(1, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (get_res(1, 3) !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fffffff", get_res(1, 3)); end
        fb = first_bad(1);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL sat_pos_all: lane %0d got %h expected %h", fb, get_res(1, fb), exp_res[fb]); end
        set_const(32'h8000_0000, 32'h7FFF_FFFF);
        compute_expected(1);
        watch(1, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (get_res(1, 5) !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg: got %h expected 80000000", get_res(1, 5)); end
    endtask

    task automatic test_relu();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'(-1520), 32'd65536);
        compute_expected(0);
        watch(0, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (get_res(0, 64) !== 32'(-1191680)) begin errors++; $display("FAIL relu_off: got %h expected %h", get_res(0, 64), 32'(-1191680)); end
        fb = first_bad(0);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL relu_off_all: lane %0d got %h expected %h", fb, get_res(0, fb), exp_res[fb]); end
        compute_expected(2);
        watch(2, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (dc != 786) begin errors++; $display("FAIL relu_latency: got cycle %0d expected 786", dc); end
        checks++;
        if (get_res(2, 0) !== 32'd0) begin errors++; $display("FAIL relu_on: got %h expected 0", get_res(2, 0)); end
    endtask

    task automatic test_random();
        int dc, ws, wc, ab, bb, hb, fb;
        for (int it = 0; it < 4; it++) begin
            set_random(it == 3 ? 32 : 14 + 3 * it, it == 3 ? 32 : 18 + it);
            compute_expected(1);
            watch(1, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
            fb = first_bad(1);
            checks++;
            if (fb != -1 || dc != 130) begin
                errors++;
                $display("FAIL random_l1[%0d]: done at %0d lane %0d got %h expected %h (done 130)",
                         it, dc, fb, (fb >= 0) ? get_res(1, fb) : 32'h0, (fb >= 0) ? exp_res[fb] : 32'h0);
            end
        end
        set_random(16, 20);
        compute_expected(2);
        watch(2, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        fb = first_bad(2);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL random_relu: lane %0d got %h expected %h", fb, get_res(2, fb), exp_res[fb]); end
    endtask

    task automatic test_start_ignored();
        int dc, ws, wc, ab, bb, hb, fb;
        set_random(15, 19);
        compute_expected(0);
        watch(0, 1'b0, 5, 400, dc, ws, wc, ab, bb, hb);
        checks++;
        if (ws != 1) begin errors++; $display("FAIL ignore_wstart: got %0d pulses expected 1", ws); end
        checks++;
        if (dc != 786) begin errors++; $display("FAIL ignore_latency: got cycle %0d expected 786", dc); end
        fb = first_bad(0);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL ignore_results: lane %0d got %h expected %h", fb, get_res(0, fb), exp_res[fb]); end
    endtask

    task automatic test_back_to_back();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'd320, 32'd65536);
        compute_expected(1);
        watch(1, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        for (int l = 0; l < L1; l++) exp_a[l] = exp_res[l];
        start_v[1] = 1'b1;
        set_random(16, 20);
        compute_expected(1);
        @(negedge clka);
        start_v[1] = 1'b0;
        checks++;
        if (get_wstart(1) !== 1'b1) begin errors++; $display("FAIL b2b_wstart: got %b expected 1", get_wstart(1)); end
        checks++;
        if (get_res(1, 2) !== exp_a[2]) begin errors++; $display("FAIL b2b_held_start: got %h expected %h", get_res(1, 2), exp_a[2]); end
        watch(1, 1'b1, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (hb != 0) begin errors++; $display("FAIL b2b_held: got %0d early result changes expected 0", hb); end
        checks++;
        if (dc != 130) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected 130", dc); end
        fb = first_bad(1);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL b2b_results: lane %0d got %h expected %h", fb, get_res(1, fb), exp_res[fb]); end
    endtask

    task automatic test_reset_mid();
        int dc, ws, wc, ab, bb, hb, fb;
        set_const(32'd1520, 32'd65536);
        @(negedge clka); start_v[0] = 1'b1;
        @(negedge clka); start_v[0] = 1'b0;
        repeat (99) @(negedge clka);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || w_start0 !== 1'b0 || act_addr0 !== 10'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got busy=%b done=%b w_start=%b addr=%0d expected all 0", busy0, done0, w_start0, act_addr0);
        end
        checks++;
        if (res0 !== '0) begin errors++; $display("FAIL midreset_result: got lane0 %h expected 0", res0[31:0]); end
        @(negedge clka);
        rst_n = 1'b1;
        compute_expected(0);
        watch(0, 1'b0, 0, 0, dc, ws, wc, ab, bb, hb);
        checks++;
        if (dc != 786) begin errors++; $display("FAIL midreset_latency: got cycle %0d expected 786", dc); end
        fb = first_bad(0);
        checks++;
        if (fb != -1) begin errors++; $display("FAIL midreset_results: lane %0d got %h expected %h", fb, get_res(0, fb), exp_res[fb]); end
    endtask

    initial begin
        for (int k = 0; k < 784; k++) act_mem[k] = '0;
        for (int l = 0; l < 128; l++) begin wbase[l] = '0; wstep[l] = '0; end
        repeat (3) @(negedge clka);
        test_reset();
        rst_n = 1'b1;
        @(negedge clka);
        test_layer0_const();
        test_layer1_const();
        test_saturate();
        test_relu();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
